sipo_deserializer: RTL and testbench

- Serial-in/parallel-out receiver. It is the receive end of the team's 4-bit MSB-first PISO shift link.
- Collects WIDTH serial bits, strobed one per clock by bit_valid, into a word.
- Presents each completed word on a registered valid/ready output port.
- Reports dropped words (overrun) with a sticky flag. Sits between the serial link and the parallel consumer.

---
 rtl/sipo_deserializer.sv | 139 +++++++++++++
 tb/tb_sipo_deserializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver for the 4-bit MSB-first PISO link, with a valid/ready output and a sticky overrun flag.
// Optional even-parity frame bit is enabled by defining SIPO_PARITY_EN.
module sipo_deserializer #(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             serial_in,
   input  logic             bit_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             overrun,
   input  logic             ovr_clr,
   output logic             parity_err
);

`ifdef SIPO_PARITY_EN
   localparam int FRAME = WIDTH + 1;

   function automatic logic even_parity_err(input logic [WIDTH-1:0] d, input logic p);
      even_parity_err = (^d) ^ p;
   endfunction
`else
   localparam int FRAME = WIDTH;
`endif

   logic [WIDTH-1:0] shift_r;
   logic [CNT_W-1:0] count_r;
   logic [WIDTH-1:0] data_out_r;
   logic             data_valid_r;
   logic             overrun_r;

   logic [CNT_W-1:0] count_base_s;
   logic [WIDTH-1:0] shift_next_s;
   logic [WIDTH-1:0] word_s;
   logic             last_bit_s;
   logic             load_s;
   logic             drop_s;
   logic             xfer_s;

   // Frame position, next shift value and output load/drop decisions.
   always_comb begin
      count_base_s = count_r;
      if (sync) begin
         count_base_s = {CNT_W{1'b0}};
      end else begin
         count_base_s = count_r;
      end
      last_bit_s = bit_valid && (count_base_s == CNT_W'(FRAME - 1));
`ifdef SIPO_PARITY_EN
      // The trailing parity bit never enters the data word.
      word_s = shift_r;
      if (last_bit_s) begin
         shift_next_s = shift_r;
      end else begin
         shift_next_s = {shift_r[WIDTH-2:0], serial_in};
      end
`else
      word_s       = {shift_r[WIDTH-2:0], serial_in};
      shift_next_s = {shift_r[WIDTH-2:0], serial_in};
`endif
      xfer_s = data_valid_r && data_ready;
      load_s = last_bit_s && (!data_valid_r || data_ready);
      drop_s = last_bit_s && data_valid_r && !data_ready;
   end

   // Serial capture: shift register and bit counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_r <= {WIDTH{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (bit_valid) begin
         shift_r <= shift_next_s;
         if (last_bit_s) begin
            count_r <= {CNT_W{1'b0}};
         end else begin
            count_r <= count_base_s + CNT_W'(1);
         end
      end else begin
         shift_r <= shift_r;
         count_r <= count_r;
      end
   end

   // Output word register and valid flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_r   <= {WIDTH{1'b0}};
         data_valid_r <= 1'b0;
      end else if (load_s) begin
         data_out_r   <= word_s;
         data_valid_r <= 1'b1;
      end else if (xfer_s) begin
         data_valid_r <= 1'b0;
      end else begin
         data_valid_r <= data_valid_r;
      end
   end

   // Sticky overrun; a new drop beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_r <= 1'b0;
      end else if (drop_s) begin
         overrun_r <= 1'b1;
      end else if (ovr_clr) begin
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= overrun_r;
      end
   end

`ifdef SIPO_PARITY_EN
   logic parity_err_r;

   // Parity result is loaded together with the word it belongs to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parity_err_r <= 1'b0;
      end else if (load_s) begin
         parity_err_r <= even_parity_err(word_s, serial_in);
      end else begin
         parity_err_r <= parity_err_r;
      end
   end

   assign parity_err = parity_err_r;
`else
   assign parity_err = 1'b0;
`endif

   assign data_out   = data_out_r;
   assign data_valid = data_valid_r;
   assign overrun    = overrun_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer (WIDTH=4) against a queue-based frame model.
module tb_sipo_deserializer;

`ifdef SIPO_PARITY_EN
   localparam int   FRAME  = 5;
   localparam logic PAR_EN = 1'b1;
`else
   localparam int   FRAME  = 4;
   localparam logic PAR_EN = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic       serial_in;
   logic       bit_valid;
   logic       sync;
   logic [3:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       overrun;
   logic       ovr_clr;
   logic       parity_err;

   int n_tests;
   int n_fail;

   // Model state: bits of the frame in progress plus the output port contents.
   logic       bit_q[$];
   logic [3:0] m_data;
   logic       m_valid;
   logic       m_ovr;
   logic       m_perr;

   sipo_deserializer #(.WIDTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .bit_valid(bit_valid),
      .sync(sync), .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .overrun(overrun), .ovr_clr(ovr_clr), .parity_err(parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      bit_q.delete();
      m_data  = 4'h0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
   endtask

   // Next-state of the port as implied by the current inputs at the coming edge.
   task automatic model_edge();
      logic       done;
      logic       drop;
      logic [3:0] w;
      logic       p;
      done = 1'b0;
      drop = 1'b0;
      w    = 4'h0;
      p    = 1'b0;
      if (bit_valid) begin
         if (sync) bit_q.delete();
         bit_q.push_back(serial_in);
         if (bit_q.size() == FRAME) begin
            done = 1'b1;
            for (int i = 0; i < 4; i++) w[3-i] = bit_q[i];
            if (PAR_EN) p = (^w) ^ bit_q[FRAME-1];
            bit_q.delete();
         end
      end
      if (done) begin
         if (!m_valid || data_ready) begin
            m_data  = w;
            m_valid = 1'b1;
            m_perr  = p;
         end else begin
            drop = 1'b1;
         end
      end else if (m_valid && data_ready) begin
         m_valid = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
   endtask

   task automatic check_model();
      chk("data_valid", {31'd0, data_valid}, {31'd0, m_valid});
      chk("data_out", {28'd0, data_out}, {28'd0, m_data});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
   endtask

   // Inputs change just after a falling edge; outputs are checked at the next falling edge.
   task automatic step(input logic s, input logic b, input logic y, input logic r, input logic c);
      serial_in  = s;
      bit_valid  = b;
      sync       = y;
      data_ready = r;
      ovr_clr    = c;
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic idle(input logic r);
      step(1'b0, 1'b0, 1'b0, r, 1'b0);
   endtask

   task automatic send_word(input logic [3:0] w, input int gap, input logic rdy,
                            input logic rdy_last, input logic sy, input logic par);
      for (int i = 0; i < FRAME; i++) begin
         logic b;
         logic last;
         b    = (i < 4) ? w[3-i] : par;
         last = (i == FRAME - 1);
         step(b, 1'b1, (i == 0) ? sy : 1'b0, last ? rdy_last : rdy, 1'b0);
         if (!last) begin
            for (int g = 0; g < gap; g++) idle(rdy);
         end
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_data_out", {28'd0, data_out}, 32'd0);
      chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      serial_in  = 1'b0;
      bit_valid  = 1'b0;
      sync       = 1'b0;
      data_ready = 1'b0;
      ovr_clr    = 1'b0;
      reset_n    = 1'b1;
      model_reset();
      @(negedge clk);
      pulse_reset();

      // 1: back-to-back bits, consumer ready
      send_word(4'b1011, 0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t1_valid", {31'd0, data_valid}, 32'd1);
      chk("t1_data", {28'd0, data_out}, 32'hB);
      idle(1'b1);
      chk("t1_valid_one_cycle", {31'd0, data_valid}, 32'd0);

      // 2: same bits with gaps
      send_word(4'b1011, 2, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t2_data", {28'd0, data_out}, 32'hB);
      chk("t2_valid", {31'd0, data_valid}, 32'd1);
      idle(1'b1);

      // 3: partial word discarded by sync
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      send_word(4'b0110, 0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t3_data", {28'd0, data_out}, 32'h6);
      idle(1'b1);

      // 4: overrun with stalled consumer, then clear
      send_word(4'hA, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      send_word(4'h5, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_data_hold", {28'd0, data_out}, 32'hA);
      chk("t4_valid", {31'd0, data_valid}, 32'd1);
      chk("t4_overrun", {31'd0, overrun}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4_ovr_clr", {31'd0, overrun}, 32'd0);
      idle(1'b1);

      // 5: transfer coincides with completion, no bubble
      send_word(4'h3, 0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t5_data3", {28'd0, data_out}, 32'h3);
      send_word(4'hC, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t5_valid", {31'd0, data_valid}, 32'd1);
      chk("t5_dataC", {28'd0, data_out}, 32'hC);
      chk("t5_no_ovr", {31'd0, overrun}, 32'd0);
      idle(1'b1);

      // 6: reset mid-word, then 4'h9 with both parity values
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      pulse_reset();
      send_word(4'h9, 0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t6_data", {28'd0, data_out}, 32'h9);
      chk("t6_perr1", {31'd0, parity_err}, {31'd0, PAR_EN});
      idle(1'b1);
      send_word(4'h9, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6_perr0", {31'd0, parity_err}, 32'd0);
      idle(1'b1);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) pulse_reset();
         step(1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 19) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
